vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Parametrised raster timing generator; successor to the fixed 640x480 generator. Timing, sync polarity and coordinate widths are parameters. Adds data-enable, registered outputs, line/frame/vblank strobes and a frame counter. Sits between the pixel-clock strobe source and the framebuffer/sprite renderers. Downstream logic consumes position and blanking from this block.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync active level (0 = active-low, 1 = active-high)
V_POL, 0, vsync active level
FRAME_W, 8, frame counter width

Ports:
i_clk  in  1  base clock
i_rst  in  1  reset; synchronous, active-high
i_pix_stb  in  1  pixel strobe; one pixel advance per cycle it is high
o_hs  out  1  horizontal sync, level per H_POL
o_vs  out  1  vertical sync, level per V_POL
o_de  out  1  high while the position is inside the active area
o_x  out  XW=$clog2(H_ACTIVE)  pixel column
o_y  out  YW=$clog2(V_ACTIVE)  pixel row
o_line_start  out  1  one-i_clk pulse when h becomes 0
o_frame_start  out  1  one-i_clk pulse when (h,v) becomes (0,0)
o_vblank_start  out  1  one-i_clk pulse when (h,v) becomes (0,V_ACTIVE)
o_frame_cnt  out  FRAME_W  completed-frame count; wraps modulo 2^FRAME_W

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Axis order: active, front porch, sync, back porch.
- Counters: h ranges 0..H_TOTAL-1 and v ranges 0..V_TOTAL-1. Counter width is $clog2(total).
- Counters advance only on clock edges where i_pix_stb=1. h wraps from H_TOTAL-1 to 0 and v increments. v wraps from V_TOTAL-1 to 0. The count never reaches H_TOTAL or V_TOTAL.
- All outputs are registered and update on the same edge as the counters. They are decoded from the new position, so there is zero latency between position and outputs. With no strobe, outputs hold, except the pulses, which clear after one i_clk cycle.
- Sync decode:
  - hsync active when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync active when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
  - The driven level is the POL value when active and its inverse otherwise.
- o_de = (h < H_ACTIVE) && (v < V_ACTIVE).
- o_x = min(h, H_ACTIVE-1) and o_y = min(v, V_ACTIVE-1). Both are truncated to XW/YW.
- o_frame_cnt increments on the edge that raises o_frame_start.
- Reset (i_rst=1 at an edge) sets:
  - h = H_TOTAL-1 and v = V_TOTAL-1.
  - o_de=0, o_hs=!H_POL, o_vs=!V_POL, o_x=0, o_y=0, all pulses 0, o_frame_cnt=0.
  - The first strobe after reset moves to (0,0) and fires o_frame_start and o_line_start with o_frame_cnt=1.
- i_rst has priority over a simultaneous i_pix_stb. Reset mid-frame abandons the frame immediately.
- i_pix_stb tied high is legal: one pixel per i_clk, and pulses fire on consecutive-position boundaries.
- The last pixel of a frame is (H_TOTAL-1, V_TOTAL-1); no extra pixel or line is added.
- Elaboration check: each timing parameter must be >= 1, otherwise $error.

Decomposition:
- Package vga_timing_pkg holds:
  - Mode constants: VGA_640x480 (above defaults) and SVGA_800x600 (800/40/128/88, 600/1/4/23, positive polarity).
  - Polarity constants POL_LOW=0 and POL_HIGH=1.
- One natural sub-module, vga_axis_counter (ACTIVE/FP/SYNC/BP parameters, i_en input).
  - Produces next position, active flag, sync flag and a wrap flag.
  - Instantiated twice: horizontal with i_en=i_pix_stb, vertical with i_en=strobe AND horizontal wrap.
- The top level does registering, polarity, clamping, pulses and the frame counter.

Test Plan:
- Defaults, strobe every 4th clk, release reset -> first strobe: o_frame_start=o_line_start=1 (one clk), o_de=1, x=0, y=0, o_frame_cnt=1.
- Defaults, strobe tied high, one line -> o_hs low for exactly 96 strobes starting h=656; o_de high for 640; o_line_start period 800 clks.
- Defaults, full frame -> o_vs low during lines 490-491 only; o_vblank_start at (0,480); next o_frame_start exactly 420000 strobes later; o_y held at 479 during blanking.
- Tiny mode (H 4/1/1/1, V 3/1/1/1, H_POL=V_POL=1, FRAME_W=2), stb high for 5 frames -> position sequence matches the scoreboard exhaustively; sync active-high; o_frame_cnt wraps 3->0.
- Reset asserted together with a strobe at (300,200) -> next edge gives the reset values; following strobe gives (0,0) and frame_start.
- i_pix_stb low for 50 clks mid-line -> h, v, x, y, de, hs, vs frozen and no pulses fire.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants for the raster timing generator: named video modes,
// sync polarity values and a width helper used to size counters and
// coordinate buses consistently across the generator, its interface and
// its sub-modules.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  localparam bit POL_LOW  = 1'b0;
  localparam bit POL_HIGH = 1'b1;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    bit          h_pol;
    bit          v_pol;
  } vga_mode_t;

  localparam vga_mode_t VGA_640x480 = '{
    h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33,
    h_pol: POL_LOW, v_pol: POL_LOW
  };

  localparam vga_mode_t SVGA_800x600 = '{
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
    h_pol: POL_HIGH, v_pol: POL_HIGH
  };

  // Width needed to hold values 0..n-1; never narrower than one bit so a
  // degenerate axis still yields a legal vector.
  function automatic int unsigned axis_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
// Bundles the pixel strobe and all raster outputs of the timing generator.
//   i_pix_stb      pixel-advance strobe (into the generator)
//   o_hs / o_vs    sync levels
//   o_de           data enable (inside active area)
//   o_x / o_y      clamped pixel coordinates
//   o_line_start, o_frame_start, o_vblank_start   one-clock strobes
//   o_frame_cnt    completed-frame count
// master: the generator side.  slave: the renderer / strobe-source side.
// -----------------------------------------------------------------------------
interface vga_timing_gen_if
  import vga_timing_pkg::*;
#(
  parameter int XW      = axis_w(640),
  parameter int YW      = axis_w(480),
  parameter int FRAME_W = 8
);

  logic               i_pix_stb;
  logic               o_hs;
  logic               o_vs;
  logic               o_de;
  logic [XW-1:0]      o_x;
  logic [YW-1:0]      o_y;
  logic               o_line_start;
  logic               o_frame_start;
  logic               o_vblank_start;
  logic [FRAME_W-1:0] o_frame_cnt;

  modport master (
    input  i_pix_stb,
    output o_hs, o_vs, o_de, o_x, o_y,
    output o_line_start, o_frame_start, o_vblank_start, o_frame_cnt
  );

  modport slave (
    output i_pix_stb,
    input  o_hs, o_vs, o_de, o_x, o_y,
    input  o_line_start, o_frame_start, o_vblank_start, o_frame_cnt
  );

endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// Combinational next-position logic for one raster axis laid out as
// active / front porch / sync / back porch.  The position register itself
// lives in the parent so all outputs can be registered on one edge.
//   i_en      advance this cycle
//   i_pos     current position (0..TOTAL-1)
//   o_next    position after this edge
//   o_active  o_next lies in the active region
//   o_sync    o_next lies in the sync region
//   o_wrap    this edge takes the axis from TOTAL-1 back to 0
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter int unsigned CW     = axis_w(ACTIVE + FP + SYNC + BP)
) (
  input  logic          i_en,
  input  logic [CW-1:0] i_pos,
  output logic [CW-1:0] o_next,
  output logic          o_active,
  output logic          o_sync,
  output logic          o_wrap
);

  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;

  logic at_last;

  assign at_last = (i_pos == CW'(TOTAL - 1));
  assign o_wrap  = i_en && at_last;

  always_comb begin
    o_next = i_pos;
    if (i_en) begin
      o_next = at_last ? '0 : i_pos + 1'b1;
    end
  end

  // Decode the position being moved to, so the parent's registered flags
  // line up with the registered position.
  assign o_active = (o_next < CW'(ACTIVE));
  assign o_sync   = (o_next >= CW'(ACTIVE + FP)) && (o_next < CW'(ACTIVE + FP + SYNC));

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised raster timing generator.  Advances one pixel per cycle in
// which the pixel strobe is high and drives registered sync, data-enable,
// clamped coordinates, line/frame/vblank strobes and a frame counter.
//   i_clk    base clock
//   i_rst    synchronous active-high reset
//   bus      vga_timing_gen_if.master (strobe in, raster outputs out)
// Reset parks the counters on the last pixel of a frame, so the first strobe
// afterwards lands on (0,0) and reports a new frame.
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_640x480.h_active,
  parameter int unsigned H_FP     = VGA_640x480.h_fp,
  parameter int unsigned H_SYNC   = VGA_640x480.h_sync,
  parameter int unsigned H_BP     = VGA_640x480.h_bp,
  parameter int unsigned V_ACTIVE = VGA_640x480.v_active,
  parameter int unsigned V_FP     = VGA_640x480.v_fp,
  parameter int unsigned V_SYNC   = VGA_640x480.v_sync,
  parameter int unsigned V_BP     = VGA_640x480.v_bp,
  parameter bit          H_POL    = POL_LOW,
  parameter bit          V_POL    = POL_LOW,
  parameter int          FRAME_W  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  vga_timing_gen_if.master bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = axis_w(H_TOTAL);
  localparam int unsigned VW      = axis_w(V_TOTAL);
  localparam int unsigned XW      = axis_w(H_ACTIVE);
  localparam int unsigned YW      = axis_w(V_ACTIVE);

  localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE - 1);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_param_check
    $error("vga_timing_gen: every timing parameter must be at least 1");
  end

  logic [HW-1:0]      h;
  logic [VW-1:0]      v;
  logic [HW-1:0]      h_next;
  logic [VW-1:0]      v_next;
  logic               h_active, h_sync, h_wrap;
  logic               v_active, v_sync, v_wrap;

  logic               hs_q, vs_q, de_q;
  logic [XW-1:0]      x_q;
  logic [YW-1:0]      y_q;
  logic               line_start_q, frame_start_q, vblank_start_q;
  logic [FRAME_W-1:0] frame_cnt_q;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .i_en     (bus.i_pix_stb),
    .i_pos    (h),
    .o_next   (h_next),
    .o_active (h_active),
    .o_sync   (h_sync),
    .o_wrap   (h_wrap)
  );

  // h_wrap already includes the strobe, so it is exactly "strobe AND line end".
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .i_en     (h_wrap),
    .i_pos    (v),
    .o_next   (v_next),
    .o_active (v_active),
    .o_sync   (v_sync),
    .o_wrap   (v_wrap)
  );

  // Position and every output are loaded together from the next position,
  // so outputs always describe the pixel currently held in h/v.  Strobes
  // default low each cycle; a frame wrap (v_wrap) is exactly the edge that
  // enters (0,0).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h              <= HW'(H_TOTAL - 1);
      v              <= VW'(V_TOTAL - 1);
      de_q           <= 1'b0;
      hs_q           <= ~H_POL;
      vs_q           <= ~V_POL;
      x_q            <= '0;
      y_q            <= '0;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
      frame_cnt_q    <= '0;
    end else begin
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
      if (bus.i_pix_stb) begin
        h              <= h_next;
        v              <= v_next;
        de_q           <= h_active && v_active;
        hs_q           <= h_sync ? H_POL : ~H_POL;
        vs_q           <= v_sync ? V_POL : ~V_POL;
        x_q            <= h_active ? XW'(h_next) : X_MAX;
        y_q            <= v_active ? YW'(v_next) : Y_MAX;
        line_start_q   <= h_wrap;
        frame_start_q  <= v_wrap;
        vblank_start_q <= h_wrap && (v_next == VW'(V_ACTIVE));
        if (v_wrap) begin
          frame_cnt_q <= frame_cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.o_hs           = hs_q;
  assign bus.o_vs           = vs_q;
  assign bus.o_de           = de_q;
  assign bus.o_x            = x_q;
  assign bus.o_y            = y_q;
  assign bus.o_line_start   = line_start_q;
  assign bus.o_frame_start  = frame_start_q;
  assign bus.o_vblank_start = vblank_start_q;
  assign bus.o_frame_cnt    = frame_cnt_q;

endmodule
